// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: round-robin arbiter that shares one RAM port among NREQ
// cache-side requesters. A grant is held until the RAM returns ACCESS, the
// transfer times out, the RAM reports ERROR, or the requester withdraws.
// Exactly one IDLE cycle always separates two grants.
module ram_rr_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NREQ-1:0]            req_ren,
    input  logic [NREQ-1:0]            req_wen,
    input  logic [NREQ*32-1:0]         req_addr,
    input  logic [NREQ*32-1:0]         req_store,
    output logic [NREQ-1:0]            req_wait,
    output logic [31:0]                req_load,
    output logic                       ramREN,
    output logic                       ramWEN,
    output logic [31:0]                ramaddr,
    output logic [31:0]                ramstore,
    input  logic [31:0]                ramload,
    input  logic [1:0]                 ramstate,
    output logic                       grant_vld,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       timeout_p,
    output logic                       error_p
);

    localparam int unsigned IDW   = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    // RAM handshake encodings used by the arbiter (FREE/BUSY need no decode)
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             timeout_q,  timeout_d;
    logic             error_q,    error_d;

    logic [NREQ-1:0]  req_act;
    logic             sel_ren;
    logic             sel_wen;
    logic             sel_act;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_store;
    logic             pick_vld;
    logic [IDW-1:0]   pick_id;
    logic [IDW-1:0]   cand;

    assign req_act = req_ren | req_wen;

    // Route the currently granted requester's command onto shared signals
    always_comb begin
        sel_ren   = 1'b0;
        sel_wen   = 1'b0;
        sel_addr  = '0;
        sel_store = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_id_q) begin
                sel_ren   = req_ren[i];
                sel_wen   = req_wen[i];
                sel_addr  = req_addr[32*i +: 32];
                sel_store = req_store[32*i +: 32];
            end
        end
        sel_act = sel_ren | sel_wen;
    end

    // Round-robin pick: first active requester scanning up from rr_ptr, with
    // the index wrapping naturally in IDW bits
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = rr_ptr_q + IDW'(k);
            if (!pick_vld && req_act[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    // Next-state logic; abort causes are ranked withdrawal > ERROR > ACCESS > timeout
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_id_d = pick_id;
                    cnt_d      = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (!sel_act) begin
                    // Withdrawal does not count as a served grant: pointer stays
                    state_d = ST_IDLE;
                end else if (ramstate == RS_ERROR) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_id_q + IDW'(1);
                    error_d  = 1'b1;
                end else if (ramstate == RS_ACCESS) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_id_q + IDW'(1);
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_IDLE;
                    rr_ptr_d  = grant_id_q + IDW'(1);
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            error_q    <= error_d;
        end
    end

    // RAM-side drive and per-requester stall; everything is quiet outside GRANT
    always_comb begin
        req_wait = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == ST_GRANT) begin
            ramWEN   = sel_wen;
            ramREN   = sel_ren & ~sel_wen;
            ramaddr  = sel_addr;
            ramstore = sel_store;
            if (sel_act && (ramstate == RS_ACCESS)) begin
                req_wait[grant_id_q] = 1'b0;
            end
        end
    end

    assign req_load  = ramload;
    assign grant_vld = (state_q == ST_GRANT);
    assign grant_id  = grant_id_q;
    assign timeout_p = timeout_q;
    assign error_p   = error_q;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Testbench for ram_rr_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural reference model.
module tb_ram_rr_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic [NREQ-1:0]       req_ren;
    logic [NREQ-1:0]       req_wen;
    logic [NREQ*32-1:0]    req_addr;
    logic [NREQ*32-1:0]    req_store;
    logic [NREQ-1:0]       req_wait;
    logic [31:0]           req_load;
    logic                  ramREN;
    logic                  ramWEN;
    logic [31:0]           ramaddr;
    logic [31:0]           ramstore;
    logic [31:0]           ramload;
    logic [1:0]            ramstate;
    logic                  grant_vld;
    logic [1:0]            grant_id;
    logic                  timeout_p;
    logic                  error_p;

    always #5 CLK = ~CLK;

    ram_rr_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req_ren   (req_ren),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_store (req_store),
        .req_wait  (req_wait),
        .req_load  (req_load),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .timeout_p (timeout_p),
        .error_p   (error_p)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: "is someone being served, who, for how many cycles"
    bit m_busy;
    int m_gid;
    int m_rr;
    int m_cnt;
    bit m_to;
    bit m_er;

    bit auto_ram;
    int ram_lat;
    int gseq[$];
    bit prev_vld;
    int wait0_lo;
    int n_to;
    int n_er;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit act(input int i);
        return req_ren[i] | req_wen[i];
    endfunction

    function automatic logic [31:0] addr_of(input int i);
        return req_addr[32*i +: 32];
    endfunction

    function automatic logic [31:0] store_of(input int i);
        return req_store[32*i +: 32];
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gid = 0; m_rr = 0; m_cnt = 0; m_to = 0; m_er = 0;
    endtask

    task automatic model_advance();
        bit found;
        if (!nRST) begin
            model_reset();
            return;
        end
        m_to = 0;
        m_er = 0;
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_rr + k) % NREQ;
                if (!found && act(c)) begin
                    found = 1; m_busy = 1; m_gid = c; m_cnt = 0;
                end
            end
        end else begin
            m_cnt = m_cnt + 1;
            if (!act(m_gid)) begin
                m_busy = 0;
            end else if (ramstate == 2'd3) begin
                m_busy = 0; m_rr = (m_gid + 1) % NREQ; m_er = 1;
            end else if (ramstate == 2'd2) begin
                m_busy = 0; m_rr = (m_gid + 1) % NREQ;
            end else if (m_cnt >= TMO) begin
                m_busy = 0; m_rr = (m_gid + 1) % NREQ; m_to = 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] ew;
        bit a;
        ew = '1;
        a  = m_busy && act(m_gid);
        if (a && ramstate == 2'd2) ew[m_gid] = 1'b0;
        check("req_wait",  req_wait, ew);
        check("ramREN",    ramREN, a && req_ren[m_gid] && !req_wen[m_gid]);
        check("ramWEN",    ramWEN, a && req_wen[m_gid]);
        check("ramaddr",   ramaddr,  m_busy ? addr_of(m_gid)  : 32'd0);
        check("ramstore",  ramstore, m_busy ? store_of(m_gid) : 32'd0);
        check("req_load",  req_load, ramload);
        check("grant_vld", grant_vld, m_busy);
        check("grant_id",  grant_id, m_gid);
        check("timeout_p", timeout_p, m_to);
        check("error_p",   error_p, m_er);
        check("rr_ptr",    dut.rr_ptr_q, m_rr);
    endtask

    // One clock cycle: inputs already set after a falling edge
    task automatic cycle();
        if (auto_ram) ramstate = (m_busy && m_cnt == ram_lat) ? 2'd2 : 2'd1;
        ramload = $urandom;
        #1;
        check_outputs();
        if (grant_vld && !prev_vld) gseq.push_back(int'(grant_id));
        prev_vld = grant_vld;
        if (!req_wait[0]) wait0_lo++;
        if (timeout_p) n_to++;
        if (error_p) n_er++;
        @(posedge CLK);
        model_advance();
        @(negedge CLK);
    endtask

    task automatic clear_reqs();
        req_ren = '0; req_wen = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        nRST = 1'b0;
        model_reset();
        cycle();
        cycle();
        nRST = 1'b1;
    endtask

    initial begin : main
        int exp2[6];
        exp2 = '{0, 1, 2, 3, 0, 1};
        nRST = 1'b0; req_ren = '0; req_wen = '0;
        req_addr = '0; req_store = '0; ramload = '0; ramstate = 2'd0;
        auto_ram = 0; ram_lat = 0; prev_vld = 0;
        wait0_lo = 0; n_to = 0; n_er = 0;
        model_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[32*i +: 32]  = 32'h1000 * (i + 1);
            req_store[32*i +: 32] = 32'hA000_0000 + i;
        end
        @(negedge CLK);
        do_reset();

        // Single read from requester 0, ACCESS three cycles after ramREN
        req_addr[31:0] = 32'h100;
        auto_ram = 1; ram_lat = 3; wait0_lo = 0;
        req_ren[0] = 1'b1;
        repeat (5) cycle();
        req_ren[0] = 1'b0;
        repeat (2) cycle();
        check("t1_wait0_cycles", wait0_lo, 1);
        check("t1_rr_ptr", dut.rr_ptr_q, 1);

        // All requesters reading: grants rotate with one IDLE cycle between
        do_reset();
        gseq.delete();
        ram_lat = 1;
        req_ren = '1;
        repeat (19) cycle();
        clear_reqs();
        cycle();
        check("t2_grant_count", gseq.size() >= 6, 1'b1);
        for (int k = 0; k < 6; k++)
            check($sformatf("t2_grant_%0d", k), (k < gseq.size()) ? gseq[k] : -1, exp2[k]);

        // Read and write together: write wins
        do_reset();
        auto_ram = 0; ramstate = 2'd1;
        req_addr[32*3 +: 32]  = 32'h40;
        req_store[32*3 +: 32] = 32'hDEADBEEF;
        req_ren[3] = 1'b1; req_wen[3] = 1'b1;
        cycle();
        #1;
        check("t3_ramWEN", ramWEN, 1'b1);
        check("t3_ramREN", ramREN, 1'b0);
        check("t3_ramstore", ramstore, 32'hDEADBEEF);
        check("t3_ramaddr", ramaddr, 32'h40);
        ramstate = 2'd2;
        cycle();
        clear_reqs();
        cycle();

        // RAM stuck BUSY: timeout after TMO grant cycles, next index served
        do_reset();
        ramstate = 2'd1; n_to = 0;
        req_ren[1] = 1'b1; req_ren[2] = 1'b1;
        repeat (11) cycle();
        #1;
        check("t4_timeout_pulses", n_to, 1);
        check("t4_next_vld", grant_vld, 1'b1);
        check("t4_next_id", grant_id, 2);
        clear_reqs();
        repeat (2) cycle();

        // ERROR during grant of requester 2
        do_reset();
        ramstate = 2'd1; n_er = 0;
        req_ren[2] = 1'b1;
        repeat (2) cycle();
        ramstate = 2'd3;
        #1;
        check("t5_wait2_held", req_wait[2], 1'b1);
        cycle();
        ramstate = 2'd1;
        clear_reqs();
        #1;
        check("t5_error_p", error_p, 1'b1);
        check("t5_rr_ptr", dut.rr_ptr_q, 3);
        cycle();
        check("t5_error_pulses", n_er, 1);

        // Withdrawal mid-grant, then asynchronous reset mid-grant
        do_reset();
        ramstate = 2'd1;
        req_ren[1] = 1'b1;
        repeat (3) cycle();
        req_ren[1] = 1'b0;
        #1;
        check("t6_withdraw_ren", ramREN, 1'b0);
        cycle();
        check("t6_rr_unchanged", dut.rr_ptr_q, 0);
        req_ren[1] = 1'b1;
        repeat (2) cycle();
        check("t6_in_grant", grant_vld, 1'b1);
        nRST = 1'b0;
        #1;
        check("t6_rst_vld", grant_vld, 1'b0);
        check("t6_rst_ren", ramREN, 1'b0);
        check("t6_rst_wait", req_wait, 4'hF);
        check("t6_rst_addr", ramaddr, 32'd0);
        model_reset();
        cycle();
        nRST = 1'b1;
        clear_reqs();
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            int r;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_ren[i] = 1'($urandom_range(0, 1));
                    req_wen[i] = ($urandom_range(0, 3) == 0);
                    req_addr[32*i +: 32]  = $urandom;
                    req_store[32*i +: 32] = $urandom;
                end
            end
            r = $urandom_range(0, 15);
            ramstate = (r == 0) ? 2'd3 : (r <= 4) ? 2'd2 : (r == 5) ? 2'd0 : 2'd1;
            nRST = ($urandom_range(0, 149) != 0);
            if (!nRST) model_reset();
            cycle();
            nRST = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
